serial_sink: RTL and testbench
==============================

Name: serial_sink

Overview:
- Receive-side terminal stage of a node's serial link; consumes the bit stream produced by `serial_source` (tx serializer output).
- Deserializes frames and checks the destination against NODE_ID.
- Buffers accepted addresses in a small show-ahead FIFO and applies backpressure upstream via `busy`.
- Keeps saturating statistics counters for traffic evaluation.

Parameters:
- NODE_ID, 0, address this sink accepts; compared against the `ADDR_SZ-bit payload.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- serial_in  in  1  serial line; idle low.
- rd_en  in  1  pop request from the consumer.
- busy  out  1  backpressure to the upstream tx; it must not start a frame while high.
- rx_data  out  `ADDR_SZ  FIFO head (payload of the oldest accepted frame).
- rx_valid  out  1  FIFO not empty.
- rx_count  out  CNT_W  frames accepted into the FIFO.
- err_count  out  CNT_W  frames whose payload != NODE_ID (misrouted).
- drop_count  out  CNT_W  matching frames lost because the FIFO was full.

Behaviour:
- Frame format: one start bit (1), then `ADDR_SZ payload bits, LSB first, one bit per clk. No stop bit; frames may be back-to-back.
- FSM states:
  - IDLE: serial_in==1 at an edge → SHIFT, bit_cnt=0. serial_in==0 → stay.
  - SHIFT: each edge stores serial_in into shift[bit_cnt] and increments bit_cnt. At the edge sampling bit `ADDR_SZ-1`, the frame completes → IDLE.
- Timing: start bit sampled at edge E0; payload bit i at edge E(i+1); completion at edge E(`ADDR_SZ). The next start bit may be sampled at E(`ADDR_SZ+1).
- Completion action, all at edge E(`ADDR_SZ), using the assembled word including the bit sampled at that edge:
  - payload != NODE_ID → err_count+1; frame discarded.
  - payload == NODE_ID and push allowed → write to FIFO; rx_count+1.
  - payload == NODE_ID and FIFO full with no concurrent pop → drop_count+1; FIFO unchanged.
- Push allowed when count < FIFO_DEPTH, or when a pop occurs at the same edge (full with simultaneous pop accepts the push).
- FIFO:
  - Show-ahead: rx_data = head entry; rx_valid = (count != 0).
  - Pop when rd_en && rx_valid. rd_en while empty is ignored.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count has log2(FIFO_DEPTH)+1 bits.
- Latency: an accepted frame appears on rx_valid/rx_data in the cycle after E(`ADDR_SZ) if the FIFO was empty.
- busy: combinational, = (count >= FIFO_DEPTH-1). This reserves one slot for a frame already in flight. busy does not depend on FSM state.
- Counters: increment by 1; saturate at all-ones and never wrap.
- rx_data when empty: holds the last written RAM contents (don't-care). Benches check it only while rx_valid=1.
- Reset, including mid-frame:
  - FSM→IDLE, bit_cnt=0, shift=0, any partial frame discarded.
  - FIFO empty: rx_valid=0, busy=0, rx_data=0 (RAM cleared).
  - rx_count = err_count = drop_count = 0.
  - The first frame after reset deasserts needs a fresh start bit.

Test Plan (`ADDR_SZ=4, NODE_ID=5, FIFO_DEPTH=4):
- Single frame: serial_in 1,1,0,1,0 on E0..E4 → after E4, rx_valid=1, rx_data=5, rx_count=1; rd_en for one cycle → rx_valid=0.
- Misrouted: frame payload 3 (1,1,1,0,0) → err_count=1, rx_valid stays 0, rx_count=0.
- Fill/backpressure: three back-to-back payload-5 frames, no rd_en → busy=1 once count=3. A fourth frame sent anyway → count=4. A fifth → drop_count=1, count stays 4.
- Full plus simultaneous pop: FIFO full, rd_en high on the completion edge of a payload-5 frame → push accepted, count stays 4, rx_count increments, drop_count unchanged.
- Reset mid-frame: assert reset after payload bit 1 → all outputs 0. After release, line held 0 for 10 cycles → no frame and counters stay 0. A clean frame then → rx_count=1.
- Saturation (CNT_W=2 override): 5 misrouted frames → err_count=3, not 1.

Source files
------------

// File: rtl/serial_sink.sv
// Receive terminal of the node serial link: deserializes start-bit framed addresses,
// keeps frames addressed to NODE_ID in a show-ahead FIFO and tracks saturating traffic stats.
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module serial_sink #(
   parameter int NODE_ID    = 0,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                serial_in,
   input  logic                rd_en,
   output logic                busy,
   output logic [`ADDR_SZ-1:0] rx_data,
   output logic                rx_valid,
   output logic [CNT_W-1:0]    rx_count,
   output logic [CNT_W-1:0]    err_count,
   output logic [CNT_W-1:0]    drop_count
);

   localparam int AW = `ADDR_SZ;
   localparam int BW = (AW > 1) ? $clog2(AW) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [AW-1:0] MY_ADDR   = AW'(NODE_ID);
   localparam logic [BW-1:0] LAST_BIT  = BW'(AW - 1);
   localparam logic [PW:0]   DEPTH     = (PW + 1)'(FIFO_DEPTH);
   localparam logic [PW:0]   BUSY_LVL  = (PW + 1)'(FIFO_DEPTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state_q;
   logic [BW-1:0]   bit_cnt_q;
   logic [AW-1:0]   shift_q;
   logic [AW-1:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PW:0]     count_q, count_d;
   logic [CNT_W-1:0] rx_cnt_q, err_cnt_q, drop_cnt_q;

   logic [AW-1:0]   word_d;
   logic            frame_done, match, pop, push, drop, misroute;

   // The completing word must include the bit sampled on the completion edge itself.
   always_comb begin
      word_d             = shift_q;
      word_d[bit_cnt_q]  = serial_in;
      frame_done         = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
      match              = (word_d == MY_ADDR);
      pop                = rd_en && (count_q != '0);
      push               = frame_done && match && ((count_q != DEPTH) || pop);
      drop               = frame_done && match && !push;
      misroute           = frame_done && !match;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               bit_cnt_q <= '0;
               if (serial_in) state_q <= SHIFT;
            end
            SHIFT: begin
               shift_q <= word_d;
               if (frame_done) begin
                  bit_cnt_q <= '0;
                  state_q   <= IDLE;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= word_d;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Statistics saturate at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_cnt_q   <= '0;
         err_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (push && (rx_cnt_q != '1))       rx_cnt_q   <= rx_cnt_q + 1'b1;
         if (misroute && (err_cnt_q != '1))  err_cnt_q  <= err_cnt_q + 1'b1;
         if (drop && (drop_cnt_q != '1))     drop_cnt_q <= drop_cnt_q + 1'b1;
      end
   end

   assign busy       = (count_q >= BUSY_LVL);
   assign rx_valid   = (count_q != '0);
   assign rx_data    = mem_q[rd_ptr_q];
   assign rx_count   = rx_cnt_q;
   assign err_count  = err_cnt_q;
   assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_serial_sink.sv
// Bench for serial_sink: directed scenarios plus randomized frames checked against a
// frame-level queue model; a second instance with 2-bit counters covers saturation.
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module tb_serial_sink;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic serial_in = 1'b0, rd_en = 1'b0;
   logic si2 = 1'b0, rd2 = 1'b0;

   logic        busy, rx_valid;
   logic [3:0]  rx_data;
   logic [15:0] rx_count, err_count, drop_count;

   logic        busy2, rx_valid2;
   logic [3:0]  rx_data2;
   logic [1:0]  rx_count2, err_count2, drop_count2;

   int checks = 0;
   int passed = 0;

   logic [3:0] mq[$];
   int m_rx, m_err, m_drop;
   localparam int MAXC = 65535;

   always #5 clk = ~clk;

   serial_sink #(.NODE_ID(5), .FIFO_DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .serial_in(serial_in), .rd_en(rd_en),
      .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_count(rx_count), .err_count(err_count), .drop_count(drop_count));

   serial_sink #(.NODE_ID(5), .FIFO_DEPTH(4), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .serial_in(si2), .rd_en(rd2),
      .busy(busy2), .rx_data(rx_data2), .rx_valid(rx_valid2),
      .rx_count(rx_count2), .err_count(err_count2), .drop_count(drop_count2));

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic do_reset();
      serial_in = 1'b0;
      rd_en     = 1'b0;
      si2       = 1'b0;
      rd2       = 1'b0;
      reset     = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset  = 1'b0;
      mq.delete();
      m_rx = 0; m_err = 0; m_drop = 0;
   endtask

   // Drives one frame; rd_last is the rd_en value on the completion edge.
   task automatic send_frame(input logic [3:0] p, input logic rd_last);
      logic [4:0] fb;
      bit         pop_ok;
      bit         full;
      fb = {p, 1'b1};
      for (int i = 0; i < 5; i++) begin
         serial_in = fb[i];
         rd_en     = (i == 4) ? rd_last : 1'b0;
         @(posedge clk);
         #1;
      end
      serial_in = 1'b0;
      rd_en     = 1'b0;
      full   = (mq.size() == 4);
      pop_ok = rd_last && (mq.size() > 0);
      if (pop_ok) void'(mq.pop_front());
      if (p != 4'd5) begin
         if (m_err < MAXC) m_err++;
      end else if (!full || pop_ok) begin
         mq.push_back(p);
         if (m_rx < MAXC) m_rx++;
      end else begin
         if (m_drop < MAXC) m_drop++;
      end
   endtask

   task automatic idle(input int n, input bit rand_rd);
      for (int i = 0; i < n; i++) begin
         serial_in = 1'b0;
         rd_en     = rand_rd ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk);
         #1;
         if (rd_en && mq.size() > 0) void'(mq.pop_front());
      end
      rd_en = 1'b0;
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      if (mq.size() > 0) void'(mq.pop_front());
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      checks++; if (rx_data !== 4'd0) $display("FAIL reset_data: got %0d want 0", rx_data); else passed++;
      checks++; if ({rx_count, err_count, drop_count} !== 48'd0)
         $display("FAIL reset_counters: got rx=%0d err=%0d drop=%0d want 0", rx_count, err_count, drop_count);
      else passed++;
   endtask

   task automatic test_single();
      do_reset();
      send_frame(4'd5, 1'b0);
      checks++; if (rx_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", rx_valid); else passed++;
      checks++; if (rx_data !== 4'd5) $display("FAIL single_data: got %0d want 5", rx_data); else passed++;
      checks++; if (rx_count !== 16'd1) $display("FAIL single_rxcount: got %0d want 1", rx_count); else passed++;
      pop_one();
      checks++; if (rx_valid !== 1'b0) $display("FAIL single_popped: got %b want 0", rx_valid); else passed++;
      rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
      checks++; if (rx_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL empty_pop_ignored: got valid=%b busy=%b want 0 0", rx_valid, busy);
      else passed++;
   endtask

   task automatic test_misrouted();
      do_reset();
      send_frame(4'd3, 1'b0);
      checks++; if (err_count !== 16'd1) $display("FAIL misroute_err: got %0d want 1", err_count); else passed++;
      checks++; if (rx_valid !== 1'b0) $display("FAIL misroute_valid: got %b want 0", rx_valid); else passed++;
      checks++; if (rx_count !== 16'd0) $display("FAIL misroute_rx: got %0d want 0", rx_count); else passed++;
   endtask

   task automatic test_fill();
      do_reset();
      send_frame(4'd5, 1'b0);
      send_frame(4'd5, 1'b0);
      checks++; if (busy !== 1'b0) $display("FAIL fill_busy_at2: got %b want 0", busy); else passed++;
      send_frame(4'd5, 1'b0);
      checks++; if (busy !== 1'b1) $display("FAIL fill_busy_at3: got %b want 1", busy); else passed++;
      send_frame(4'd5, 1'b0);
      checks++; if (rx_count !== 16'd4 || drop_count !== 16'd0)
         $display("FAIL fill_fourth: got rx=%0d drop=%0d want 4 0", rx_count, drop_count);
      else passed++;
      send_frame(4'd5, 1'b0);
      checks++; if (rx_count !== 16'd4 || drop_count !== 16'd1)
         $display("FAIL fill_drop: got rx=%0d drop=%0d want 4 1", rx_count, drop_count);
      else passed++;
      send_frame(4'd5, 1'b1);
      checks++; if (rx_count !== 16'd5 || drop_count !== 16'd1 || busy !== 1'b1)
         $display("FAIL full_pop_push: got rx=%0d drop=%0d busy=%b want 5 1 1", rx_count, drop_count, busy);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         checks++; if (rx_valid !== 1'b1 || rx_data !== 4'd5)
            $display("FAIL drain_%0d: got valid=%b data=%0d want 1 5", i, rx_valid, rx_data);
         else passed++;
         pop_one();
      end
      checks++; if (rx_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL drain_empty: got valid=%b busy=%b want 0 0", rx_valid, busy);
      else passed++;
   endtask

   task automatic test_reset_midframe();
      do_reset();
      send_frame(4'd5, 1'b0);
      send_frame(4'd3, 1'b0);
      serial_in = 1'b1; @(posedge clk); #1;
      serial_in = 1'b1; @(posedge clk); #1;
      serial_in = 1'b0; @(posedge clk); #1;
      serial_in = 1'b1;
      #2 reset = 1'b1;
      #1;
      checks++; if ({rx_valid, busy, rx_data} !== 6'd0 || {rx_count, err_count, drop_count} !== 48'd0)
         $display("FAIL midframe_async: got valid=%b busy=%b data=%0d rx=%0d err=%0d want all 0",
                  rx_valid, busy, rx_data, rx_count, err_count);
      else passed++;
      serial_in = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      mq.delete(); m_rx = 0; m_err = 0; m_drop = 0;
      idle(10, 1'b0);
      checks++; if (rx_valid !== 1'b0 || rx_count !== 16'd0 || err_count !== 16'd0 || drop_count !== 16'd0)
         $display("FAIL midframe_quiet: got valid=%b rx=%0d err=%0d drop=%0d want 0", rx_valid, rx_count, err_count, drop_count);
      else passed++;
      send_frame(4'd5, 1'b0);
      checks++; if (rx_count !== 16'd1 || rx_valid !== 1'b1 || rx_data !== 4'd5)
         $display("FAIL midframe_clean: got rx=%0d valid=%b data=%0d want 1 1 5", rx_count, rx_valid, rx_data);
      else passed++;
   endtask

   task automatic test_random();
      logic [3:0] p;
      do_reset();
      for (int n = 0; n < 60; n++) begin
         p = ($urandom_range(0, 1) == 0) ? 4'd5 : 4'($urandom_range(0, 15));
         send_frame(p, ($urandom_range(0, 2) == 0));
         checks++; if (rx_valid !== (mq.size() > 0))
            $display("FAIL rand_valid[%0d]: got %b want %b", n, rx_valid, (mq.size() > 0));
         else passed++;
         if (mq.size() > 0) begin
            checks++; if (rx_data !== mq[0]) $display("FAIL rand_data[%0d]: got %0d want %0d", n, rx_data, mq[0]);
            else passed++;
         end
         checks++; if (busy !== (mq.size() >= 3))
            $display("FAIL rand_busy[%0d]: got %b want %b", n, busy, (mq.size() >= 3));
         else passed++;
         checks++; if (rx_count !== 16'(m_rx) || err_count !== 16'(m_err) || drop_count !== 16'(m_drop))
            $display("FAIL rand_counts[%0d]: got rx=%0d err=%0d drop=%0d want %0d %0d %0d",
                     n, rx_count, err_count, drop_count, m_rx, m_err, m_drop);
         else passed++;
         idle($urandom_range(0, 2), 1'b1);
      end
   endtask

   task automatic test_saturation();
      logic [4:0] fb;
      do_reset();
      fb = {4'd3, 1'b1};
      for (int f = 0; f < 5; f++) begin
         for (int i = 0; i < 5; i++) begin
            si2 = fb[i];
            @(posedge clk);
            #1;
         end
         si2 = 1'b0;
         if (f == 2) begin
            checks++; if (err_count2 !== 2'd3) $display("FAIL sat_reach: got %0d want 3", err_count2); else passed++;
         end
      end
      checks++; if (err_count2 !== 2'd3) $display("FAIL sat_hold: got %0d want 3", err_count2); else passed++;
      checks++; if (rx_count2 !== 2'd0 || rx_valid2 !== 1'b0)
         $display("FAIL sat_rx: got rx=%0d valid=%b want 0 0", rx_count2, rx_valid2);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_misrouted();
      test_fill();
      test_reset_midframe();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
